sipo: RTL and testbench

Serial-in/parallel-out deserializer. It captures one serial bit per enabled clock edge into a WIDTH-bit shift register. It exposes the whole register as a parallel word and flags each completed WIDTH-bit frame. It sits at the front of the vertex-input path: a host streams packed fixed-point vertex data in, and downstream logic reads `out` as six 16-bit 10.6 fields, v0x, v1x, v2x, v0y, v1y and v2y, in `out[15:0]` through `out[95:80]`.

---
 rtl/sipo_if.sv | 15 +
 rtl/sipo.sv | 45 ++++
 tb/tb_sipo.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sipo_if.sv
// Serial-in/parallel-out bus: host drives en/in, deserializer returns word, frame count and frame pulse.
interface sipo_if #(
   parameter int WIDTH = 144
);
   localparam int CW = $clog2(WIDTH);

   logic             en;
   logic             in;
   logic [WIDTH-1:0] out;
   logic [CW-1:0]    count;
   logic             valid;

   modport master (output en, output in, input out, input count, input valid);
   modport slave  (input en, input in, output out, output count, output valid);
endinterface

// File: rtl/sipo.sv
// Serial-in/parallel-out deserializer; 1-edge capture latency, valid pulses once per WIDTH-bit frame.
// No backpressure: downstream samples out while valid is high. SIPO_MSB_FIRST_EN selects MSB-first shifting.
module sipo #(
   parameter int WIDTH = 144
) (
   input  logic  clk,
   input  logic  rst_n,
   sipo_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] r_out;
   logic [CW-1:0]    r_count;
   logic             r_valid;
   logic [WIDTH-1:0] w_shift;
   logic             w_last;

   assign w_last = (r_count == CW'(WIDTH - 1));

`ifdef SIPO_MSB_FIRST_EN
   assign w_shift = {r_out[WIDTH-2:0], bus.in};
`else
   assign w_shift = {bus.in, r_out[WIDTH-1:1]};
`endif

   // out is never cleared between frames; a new frame shifts over the old one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out   <= '0;
         r_count <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (bus.en) begin
            r_out   <= w_shift;
            r_count <= w_last ? '0 : r_count + 1'b1;
            r_valid <= w_last;
         end
      end
   end

   assign bus.out   = r_out;
   assign bus.count = r_count;
   assign bus.valid = r_valid;
endmodule

// File: tb/tb_sipo.sv
// Bench for sipo: vector table, directed frame sequences, and random stream against a bit-history model.
module tb_sipo;
   localparam int W = 144;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   sipo_if #(.WIDTH(W)) bus ();

   sipo #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: every enabled bit since reset, oldest first.
   logic hist[$];
   int   total;
   logic m_valid;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] exp_out();
      logic [W-1:0] r;
      int n;
      r = '0;
      n = hist.size();
      for (int i = 0; i < W; i++) begin
         int k;
`ifdef SIPO_MSB_FIRST_EN
         k = i;
`else
         k = W - 1 - i;
`endif
         if (n - 1 - k >= 0) r[i] = hist[n-1-k];
      end
      return r;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".out"},   bus.out, exp_out());
      chk({tag, ".count"}, W'(bus.count), W'(total % W));
      chk({tag, ".valid"}, W'(bus.valid), W'(m_valid));
   endtask

   task automatic step(input logic e, input logic b);
      @(negedge clk);
      bus.en = e;
      bus.in = b;
      @(posedge clk);
      #1;
      m_valid = 1'b0;
      if (e) begin
         hist.push_back(b);
         total++;
         m_valid = (total % W == 0);
      end
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      bus.en = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk({tag, ".rst_out"},   bus.out, '0);
      chk({tag, ".rst_count"}, W'(bus.count), '0);
      chk({tag, ".rst_valid"}, W'(bus.valid), '0);
      hist.delete();
      total   = 0;
      m_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic order_bit(input logic [W-1:0] m, input int j);
`ifdef SIPO_MSB_FIRST_EN
      return m[W-1-j];
`else
      return m[j];
`endif
   endfunction

   task automatic send_msg(input string tag, input logic [W-1:0] m, input int gap_a, input int gap_b,
                           output int pulses);
      logic [W-1:0] frz_out;
      logic [W-1:0] frz_cnt;
      pulses = 0;
      for (int j = 0; j < W; j++) begin
         step(1'b1, order_bit(m, j));
         check_all(tag);
         if (bus.valid) begin
            pulses++;
            chk({tag, ".out_at_valid"}, bus.out, m);
         end
         if (j + 1 == gap_a || j + 1 == gap_b) begin
            frz_out = bus.out;
            frz_cnt = W'(bus.count);
            for (int g = 0; g < 5; g++) begin
               step(1'b0, 1'($urandom_range(1)));
               chk({tag, ".gap_out"},   bus.out, frz_out);
               chk({tag, ".gap_count"}, W'(bus.count), frz_cnt);
               chk({tag, ".gap_valid"}, W'(bus.valid), '0);
            end
         end
      end
   endtask

   typedef struct {
      logic       en;
      logic       in;
      int         cnt;
      logic [3:0] top4;
   } vec_t;

   vec_t vecs[7];

   logic [W-1:0] msg;
   logic [W-1:0] ones;
   logic [W-1:0] one;
   logic [3:0]   w_top4;
   int           pulses;
   int           rpulses;

`ifdef SIPO_MSB_FIRST_EN
   assign w_top4 = {bus.out[0], bus.out[1], bus.out[2], bus.out[3]};
`else
   assign w_top4 = bus.out[W-1:W-4];
`endif

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      bus.en   = 1'b0;
      bus.in   = 1'b0;
      total    = 0;
      m_valid  = 1'b0;

      vecs[0] = '{1'b1, 1'b1, 1, 4'b1000};
      vecs[1] = '{1'b1, 1'b0, 2, 4'b0100};
      vecs[2] = '{1'b0, 1'b1, 2, 4'b0100};
      vecs[3] = '{1'b1, 1'b1, 3, 4'b1010};
      vecs[4] = '{1'b1, 1'b1, 4, 4'b1101};
      vecs[5] = '{1'b0, 1'b0, 4, 4'b1101};
      vecs[6] = '{1'b1, 1'b0, 5, 4'b0110};

      #12;
      chk("por_out",   bus.out, '0);
      chk("por_count", W'(bus.count), '0);
      chk("por_valid", W'(bus.valid), '0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 7; v++) begin
         step(vecs[v].en, vecs[v].in);
         chk($sformatf("vec%0d.count", v), W'(bus.count), W'(vecs[v].cnt));
         chk($sformatf("vec%0d.top4", v),  W'(w_top4), W'(vecs[v].top4));
         chk($sformatf("vec%0d.valid", v), W'(bus.valid), '0);
      end

      // Reset asserted in the middle of a frame, then a clean frame
      for (int j = 0; j < 50; j++) step(1'b1, 1'($urandom_range(1)));
      do_reset("midrst");

      msg = '0;
      msg[15:0]  = 16'h5555;
      msg[31:16] = 16'hFFC0;
      msg[47:32] = 16'h003F;
      msg[63:48] = 16'hAAAA;
      msg[79:64] = 16'h003F;
      msg[95:80] = 16'hFFC0;
      send_msg("vertex", msg, -1, -1, pulses);
      chk("vertex.out_final", bus.out, msg);
      chk("vertex.pulses", W'(pulses), W'(1));

      do_reset("gaps_rst");
      send_msg("gaps", msg, 10, 100, pulses);
      chk("gaps.out_final", bus.out, msg);
      chk("gaps.pulses", W'(pulses), W'(1));

      do_reset("b2b_rst");
      ones = '1;
      one  = W'(1);
      send_msg("b2b_ones", ones, -1, -1, pulses);
      chk("b2b_ones.pulses", W'(pulses), W'(1));
      chk("b2b_ones.out", bus.out, ones);
      send_msg("b2b_one", one, -1, -1, pulses);
      chk("b2b_one.pulses", W'(pulses), W'(1));
      chk("b2b_one.out", bus.out, one);
      chk("b2b_one.total", W'(total), W'(2 * W));

      do_reset("part_rst");
      pulses = 0;
      for (int j = 0; j < W - 1; j++) begin
         step(1'b1, 1'($urandom_range(1)));
         check_all("part");
         if (bus.valid) pulses++;
      end
      chk("part.count", W'(bus.count), W'(W - 1));
      chk("part.pulses", W'(pulses), '0);

      do_reset("rand_rst");
      rpulses = 0;
      for (int j = 0; j < 3000; j++) begin
         step(($urandom_range(3) != 0), 1'($urandom_range(1)));
         check_all("rand");
         if (m_valid) rpulses++;
      end
      chk("rand.pulses", W'(rpulses), W'(total / W));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
